gpio_in_dev: RTL
================

# gpio_in_dev

CPU-readable input peripheral for board switches and push-buttons, the read-side counterpart of the GPIO LED/counter-control output port. It synchronises and debounces 8 switches and 4 buttons, latches button presses into sticky flags, counts presses, and presents one 32-bit status word on the peripheral read bus. Sticky flags clear on read, and an interrupt request is raised while any flag is pending.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive clocks an input must differ from its debounced value before the change is accepted (1 ms at 50 MHz); minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- rst  in  1  reset, asynchronous, active-high.
- sw_in  in  8  raw slide switches, asynchronous to clk.
- btn_in  in  4  raw push-buttons, active-high, asynchronous to clk.
- rd_en  in  1  one-cycle CPU read strobe for the status word.
- rd_data  out  32  status word, combinational from registers.
- irq  out  1  high while any sticky press flag is set.

## Operation
- Per input bit (12 total): a 2-FF synchroniser produces sync2, feeding a debouncer with counter cnt and a debounced output stable.
  - sync2 == stable: cnt <= 0.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - cnt width is $clog2(DEBOUNCE_CYCLES).
- Press detect: a btn[i] debounced rising edge (stable 0->1 on this edge) sets press_flag[i].
  - Falling edges have no effect on the flags.
- Press counter press_cnt, 8 bits: adds the number of buttons with a rising edge on this edge (0..4). Arithmetic is modulo 256 and wraps silently.
- Clear-on-read: on an edge with rd_en=1, press_flag <= new_rises, i.e. all old flags clear.
  - A rise on the same edge wins, so its flag is set after the read.
  - press_cnt is not cleared by reads.
- rd_data layout:
  - [7:0] sw stable
  - [11:8] btn stable
  - [15:12] press_flag
  - [23:16] press_cnt
  - [31:24] 0
- irq = |press_flag, registered so it changes on the same edge as the flags.
- Reset values: all sync FFs, stable, cnt, press_flag, press_cnt = 0. Hence rd_data = 32'h0 and irq = 0 during and immediately after reset.
- Reset mid-debounce: the count is discarded. After release, a still-differing input needs the full latency again.

## Timing
- Latency: new raw level first sampled at edge k reaches sync2 after edge k+1. stable updates at edge k+1+DEBOUNCE_CYCLES, so rd_data reflects it DEBOUNCE_CYCLES+2 edges after first sampling.
- A raw glitch shorter than DEBOUNCE_CYCLES clocks at sync2 never changes stable; cnt returns to 0.
- A debounced press sets its flag, bumps press_cnt, and raises irq on the same edge stable rises.
- rd_data during the rd_en cycle shows pre-clear flags. Flags and irq clear at that edge.
- rd_en held high for multiple cycles clears on every edge; each cycle is a separate read.
- No bus wait states; rd_data is valid every cycle.

## Structure
- Shared package: rd_data field offsets (SW_LSB=0, BTN_LSB=8, FLAG_LSB=12, CNT_LSB=16), N_SW=8, N_BTN=4.
- Sub-module debounce_bit (param DEBOUNCE_CYCLES; ports clk, rst, raw, stable, rise): contains the synchroniser, counter and edge pulse. It is instantiated 12 times via generate; only the button instances use rise.
- Top level holds press_flag, press_cnt, the popcount adder, irq and the read mux.

## Test plan
Benches override DEBOUNCE_CYCLES=4.
- Reset: assert rst asynchronously mid-cycle with sw_in=8'hFF -> rd_data=32'h0 and irq=0 immediately; after release, rd_data[7:0]=8'hFF exactly 6 edges after the first sampling edge.
- Switch settle: sw_in 8'h00->8'hA5 held -> rd_data[7:0] stays 8'h00 for 5 edges and becomes 8'hA5 on the 6th; bits [15:12] remain 0.
- Glitch reject: btn_in[0] high for 3 clocks then low -> rd_data[8]=0, flag 0, press_cnt 0, irq 0 throughout.
- Press and read: btn_in[1] held 10 clocks -> rd_data[9]=1, rd_data[13]=1, rd_data[23:16]=8'h01, irq=1. One-cycle rd_en -> next cycle rd_data[13]=0, irq=0, rd_data[9] still 1.
- Simultaneous: flag for btn1 pending; btn2 and btn3 stable rise on the same edge as rd_en -> flags become 4'b1100, press_cnt +2, irq stays 1.
- Wrap/reset: 256 debounced presses of btn0 -> press_cnt reads 8'h00. Pulse rst while btn0 is mid-debounce (cnt=2) -> after release, the press is accepted only after the full 6-edge latency.

Source files
------------

// File: rtl/gpio_in_dev_pkg.sv
// Shared constants and helpers for the switch/button input peripheral.
package gpio_in_dev_pkg;

  localparam int N_SW    = 8;
  localparam int N_BTN   = 4;
  localparam int N_IN    = N_SW + N_BTN;

  // Status word field offsets
  localparam int SW_LSB   = 0;
  localparam int BTN_LSB  = 8;
  localparam int FLAG_LSB = 12;
  localparam int CNT_LSB  = 16;

  localparam int PCNT_W   = 8;
  localparam int RD_W     = 32;

  // Number of buttons that rose on this edge (0..N_BTN)
  function automatic logic [2:0] popcount_btn(input logic [N_BTN-1:0] v);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < N_BTN; i++) s = s + 3'(v[i]);
    return s;
  endfunction

endpackage

// File: rtl/gpio_in_dev_debounce_bit.sv
// One input bit: 2-FF synchroniser, saturating-window debouncer and a
// combinational rising-edge pulse that coincides with the stable update.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state: shift the synchroniser, count consecutive differing cycles
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset also discards any partial debounce count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  // High in the cycle before the edge on which stable goes 0->1, so the
  // consumer can act on that same edge.
  assign rise   = stable_d & ~stable_q;

endmodule

// File: rtl/gpio_in_dev.sv
// Switch/button read port: debounced levels, sticky press flags with
// clear-on-read, a wrapping press counter and a level interrupt.
module gpio_in_dev
  import gpio_in_dev_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_in,
  input  logic [N_BTN-1:0] btn_in,
  input  logic            rd_en,
  output logic [RD_W-1:0] rd_data,
  output logic            irq
);

  logic [N_SW-1:0]   sw_stable, sw_rise;
  logic [N_BTN-1:0]  btn_stable, btn_rise;

  logic [N_BTN-1:0]  press_flag_q, press_flag_d;
  logic [PCNT_W-1:0] press_cnt_q, press_cnt_d;
  logic              irq_q, irq_d;

  // Switch edges are not needed; fold them into a sink so nothing dangles.
  logic unused_sw_rise;
  assign unused_sw_rise = ^sw_rise;

  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_sw
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk    (clk),
        .rst    (rst),
        .raw    (sw_in[gi]),
        .stable (sw_stable[gi]),
        .rise   (sw_rise[gi])
      );
    end
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk    (clk),
        .rst    (rst),
        .raw    (btn_in[gi]),
        .stable (btn_stable[gi]),
        .rise   (btn_rise[gi])
      );
    end
  endgenerate

  // Flags: a read drops old flags, but a rise on the read edge survives it
  always_comb begin
    press_flag_d = rd_en ? btn_rise : (press_flag_q | btn_rise);
    press_cnt_d  = press_cnt_q + PCNT_W'(popcount_btn(btn_rise));
    irq_d        = |press_flag_d;
  end

  // Press state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_flag_q <= '0;
      press_cnt_q  <= '0;
      irq_q        <= 1'b0;
    end else begin
      press_flag_q <= press_flag_d;
      press_cnt_q  <= press_cnt_d;
      irq_q        <= irq_d;
    end
  end

  // Status word assembled purely from registered state
  always_comb begin
    rd_data = '0;
    rd_data[SW_LSB   +: N_SW]   = sw_stable;
    rd_data[BTN_LSB  +: N_BTN]  = btn_stable;
    rd_data[FLAG_LSB +: N_BTN]  = press_flag_q;
    rd_data[CNT_LSB  +: PCNT_W] = press_cnt_q;
  end

  assign irq = irq_q;

endmodule
